panda_data_mem_arbiter: RTL

Shares the single-port data memory between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug). Round-robin arbitration with same-cycle grant, read data returned on the following cycle, and a lock mechanism so one port can hold the memory for read-modify-write sequences. Sits between the requesters and the data memory, driving the byte-enable write interface.

---
 rtl/panda_data_mem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/panda_data_mem_arbiter.sv
// panda_data_mem_arbiter
//   Shares the single-port data memory between port 0 (core LSU) and port 1
//   (DMA/debug). It uses round-robin arbitration with a same-cycle grant.
//   Read data comes back one cycle after the grant. A port can lock the
//   memory across several accesses for read-modify-write sequences. A lock
//   whose owner stays idle for LOCK_TIMEOUT cycles is released by force.
//
// Ports
//   clk_i, rst_i                  clock, async active-high reset
//   m{0,1}_req/lock/addr/we/wdata requester access (req held until gnt)
//   m{0,1}_gnt_o                  access accepted this cycle
//   m{0,1}_rvalid_o/rdata_o       response for the access granted last cycle
//   data_req/addr/we/wdata_o      memory access strobe and write interface
//   data_rdata_i                  memory read data (one cycle after req)
//   conflict_cnt_o                saturating blocked-request counter, only
//                                 present when PANDA_ARB_PERF_EN is defined
module panda_data_mem_arbiter #(
  parameter int LOCK_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_lock_i,
  input  logic [31:0]       m0_addr_i,
  input  logic [3:0]        m0_we_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [31:0]       m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_lock_i,
  input  logic [31:0]       m1_addr_i,
  input  logic [3:0]        m1_we_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [31:0]       m1_rdata_o,
  output logic              data_req_o,
  output logic [31:0]       data_addr_o,
  output logic [3:0]        data_we_o,
  output logic [31:0]       data_wdata_o,
  input  logic [31:0]       data_rdata_i
`ifdef PANDA_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  conflict_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOCK0, S_LOCK1} state_e;

  localparam bit             TIMEOUT_EN = (LOCK_TIMEOUT != 0);
  // The lock is released at the end of the cycle in which the idle count
  // would reach LOCK_TIMEOUT. The other port then wins arbitration in the
  // following cycle.
  localparam logic [CNT_W-1:0] TO_LAST  = TIMEOUT_EN ? CNT_W'(LOCK_TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic             last_q, last_d;      // last granted port
  logic             rvalid_q, owner_q;   // pending response and its port
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             gnt0, gnt1;
  logic             own_req, own_lock;

  // Arbitration. A locked state hands the memory only to the lock owner.
  // When both ports request while unlocked, the port that did not win last
  // time gets the grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      S_LOCK0: gnt0 = m0_req_i;
      S_LOCK1: gnt1 = m1_req_i;
      default: begin
        if (m0_req_i && m1_req_i) begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt0 = m0_req_i;
          gnt1 = m1_req_i;
        end
      end
    endcase
  end

  assign own_req  = (state_q == S_LOCK1) ? m1_req_i  : m0_req_i;
  assign own_lock = (state_q == S_LOCK1) ? m1_lock_i : m0_lock_i;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idle_cnt_d = '0;
    if (gnt0 || gnt1) last_d = gnt1;
    unique case (state_q)
      S_LOCK0, S_LOCK1: begin
        // A request from the owner is always granted. That grant takes
        // priority over a timeout that would expire in the same cycle.
        if (own_req) begin
          if (!own_lock) state_d = S_IDLE;
        end else if (TIMEOUT_EN && (idle_cnt_q == TO_LAST)) begin
          state_d = S_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: begin
        if (gnt0 && m0_lock_i)      state_d = S_LOCK0;
        else if (gnt1 && m1_lock_i) state_d = S_LOCK1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      rvalid_q   <= 1'b0;
      owner_q    <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rvalid_q   <= gnt0 || gnt1;
      owner_q    <= gnt1;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign m0_gnt_o     = gnt0;
  assign m1_gnt_o     = gnt1;
  assign data_req_o   = gnt0 || gnt1;
  assign data_addr_o  = gnt1 ? m1_addr_i  : (gnt0 ? m0_addr_i  : '0);
  assign data_we_o    = gnt1 ? m1_we_i    : (gnt0 ? m0_we_i    : '0);
  assign data_wdata_o = gnt1 ? m1_wdata_i : (gnt0 ? m0_wdata_i : '0);

  assign m0_rvalid_o  = rvalid_q && !owner_q;
  assign m1_rvalid_o  = rvalid_q &&  owner_q;
  assign m0_rdata_o   = m0_rvalid_o ? data_rdata_i : '0;
  assign m1_rdata_o   = m1_rvalid_o ? data_rdata_i : '0;

`ifdef PANDA_ARB_PERF_EN
  logic             blocked;
  logic [CNT_W-1:0] conflict_cnt_q;

  // A port that requests without a grant is either losing a conflict or
  // blocked by the other port's lock. At most one port can be refused in
  // a cycle.
  assign blocked = (m0_req_i && !gnt0) || (m1_req_i && !gnt1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                conflict_cnt_q <= '0;
    else if (blocked && (conflict_cnt_q != '1)) conflict_cnt_q <= conflict_cnt_q + 1'b1;
  end

  assign conflict_cnt_o = conflict_cnt_q;
`else
  // The build has no performance counter.
`endif

endmodule
